l1_line_arbiter: RTL and testbench

Arbitrates cache-line traffic from the L1 instruction cache (read-only) and the L1 data cache (read and write-back) onto the single 256-bit line port that feeds the L2 cache and eviction write buffer. It sits between the two L1 miss handlers and the shared lower memory hierarchy. The data side has priority, and a starvation limit guarantees instruction-side progress. Request address and data are latched at grant, so the downstream port sees stable values for the whole transaction. Grant counters are exported for performance monitoring.

---
 rtl/l1_line_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l1_line_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_line_arbiter.sv
// l1_line_arbiter: shares one 256-bit line port between the L1 I-cache (reads)
// and the L1 D-cache (reads and write-backs).
//
// The D-side wins ties until STARVE_LIMIT consecutive D grants have gone by
// with an I-side request pending. The address and write data are latched at
// grant time. The grant counters saturate instead of wrapping.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   i_read, i_addr                I-side line read request
//   i_rdata, i_resp               I-side read line / completion pulse
//   d_read, d_write               D-side read / write-back requests
//   d_addr, d_wdata               D-side line address / write line
//   d_rdata, d_resp               D-side read line / completion pulse
//   l2_read, l2_write             registered downstream strobes
//   l2_addr, l2_wdata             latched downstream address / write line
//   l2_rdata, l2_resp             downstream read line / completion pulse
//   i_grant_count, d_grant_count  saturating grant counters
module l1_line_arbiter #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_addr,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         l2_read,
    output logic         l2_write,
    output logic [31:0]  l2_addr,
    output logic [255:0] l2_wdata,
    input  logic [255:0] l2_rdata,
    input  logic         l2_resp,
    output logic [31:0]  i_grant_count,
    output logic [31:0]  d_grant_count
);
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned OFFSET_W = 5;

    localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_RD,
        D_WR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_next;
    logic          grant_i;
    logic          grant_d;
    logic          d_req;

    // The byte offset within a line is never forwarded downstream.
    logic unused_offset;
    assign unused_offset = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

    assign d_req   = d_read | d_write;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // State register and starvation streak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // Arbitration, completion and next-state decode.
    always_comb begin
        state_next  = state;
        streak_next = streak;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && i_read && (streak < LIMIT)) begin
                    grant_d     = 1'b1;
                    streak_next = streak + SW'(1);
                end else if (i_read) begin
                    // Covers both a lone I request and a starved I request.
                    grant_i     = 1'b1;
                    streak_next = '0;
                end else if (d_req) begin
                    grant_d     = 1'b1;
                    streak_next = '0;
                end
                if (grant_i) begin
                    state_next = I_BUSY;
                end else if (grant_d) begin
                    // A read and write together are handled as a write-back.
                    state_next = d_write ? D_WR : D_RD;
                end
            end
            I_BUSY: begin
                if (l2_resp) begin
                    i_resp     = 1'b1;
                    state_next = IDLE;
                end
            end
            D_RD, D_WR: begin
                if (l2_resp) begin
                    d_resp     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes register the decode of the upcoming state so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
        end else begin
            l2_read  <= (state_next == I_BUSY) || (state_next == D_RD);
            l2_write <= (state_next == D_WR);
        end
    end

    // Address and write line latched at grant, held for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l2_addr  <= '0;
            l2_wdata <= '0;
        end else if (grant_i) begin
            l2_addr <= {i_addr[AW-1:OFFSET_W], OFFSET_W'(0)};
        end else if (grant_d) begin
            l2_addr <= {d_addr[AW-1:OFFSET_W], OFFSET_W'(0)};
            if (d_write) begin
                l2_wdata <= d_wdata;
            end
        end
    end

    // Saturating grant counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_grant_count <= '0;
            d_grant_count <= '0;
        end else begin
            if (grant_i && (i_grant_count != CNT_MAX)) begin
                i_grant_count <= i_grant_count + CW'(1);
            end
            if (grant_d && (d_grant_count != CNT_MAX)) begin
                d_grant_count <= d_grant_count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_l1_line_arbiter.sv
// tb_l1_line_arbiter: randomized and directed bench for l1_line_arbiter.
// A transaction-level model tracks the owner of the line port, the starvation
// streak, the latched address and data, and the grant counters. All DUT outputs
// are compared against the model once per cycle.
module tb_l1_line_arbiter;
    localparam int STARVE_LIMIT = 2;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_addr;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;
    logic [31:0]  i_grant_count;
    logic [31:0]  d_grant_count;

    l1_line_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: owner 0 = none, 1 = I read, 2 = D read, 3 = D write-back.
    int           m_owner;
    int           m_streak;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic [31:0]  m_icnt;
    logic [31:0]  m_dcnt;
    int           wait_cnt;

    // Requester agents and random knobs (percent).
    logic ireq_pend, dreq_pend, dwr_pend, dboth_pend;
    int   p_i, p_d, p_stray, p_err;

    // Observed completion order: 1 = I, 0 = D, newest in the LSB.
    logic [5:0] order;
    int         n_resp;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_owner    = 0;
        m_streak   = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_icnt     = '0;
        m_dcnt     = '0;
        wait_cnt   = 0;
        ireq_pend  = 1'b0;
        dreq_pend  = 1'b0;
        dwr_pend   = 1'b0;
        dboth_pend = 1'b0;
    endtask

    task automatic clear_inputs;
        i_read   = 1'b0;
        i_addr   = '0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_rdata = '0;
        l2_resp  = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Randomized requesters and L2 responder; called at a falling edge.
    task automatic drive_random;
        if (!ireq_pend && ($urandom_range(99) < 32'(p_i))) ireq_pend = 1'b1;
        if (!dreq_pend && ($urandom_range(99) < 32'(p_d))) begin
            dreq_pend  = 1'b1;
            dwr_pend   = 1'($urandom_range(1));
            dboth_pend = ($urandom_range(99) < 32'(p_err));
        end
        i_read   = ireq_pend;
        d_read   = dreq_pend && (!dwr_pend || dboth_pend);
        d_write  = dreq_pend && (dwr_pend || dboth_pend);
        i_addr   = $urandom;
        d_addr   = $urandom;
        d_wdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        l2_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (m_owner != 0) begin
            l2_resp = (wait_cnt == 0);
            if (wait_cnt > 0) wait_cnt--;
        end else begin
            l2_resp = ($urandom_range(99) < 32'(p_stray));
        end
    endtask

    // Compare this cycle's outputs, advance the model across the rising edge,
    // and return at the next falling edge.
    task automatic tick;
        logic xi, xd, dreq;
        #1;
        xi = (m_owner == 1) && l2_resp;
        xd = (m_owner >= 2) && l2_resp;
        check("i_resp", 256'(i_resp), 256'(xi));
        check("d_resp", 256'(d_resp), 256'(xd));
        check("l2_read", 256'(l2_read), 256'((m_owner == 1) || (m_owner == 2)));
        check("l2_write", 256'(l2_write), 256'(m_owner == 3));
        check("l2_addr", 256'(l2_addr), 256'(m_addr));
        check("l2_wdata", l2_wdata, m_wdata);
        check("i_grant_count", 256'(i_grant_count), 256'(m_icnt));
        check("d_grant_count", 256'(d_grant_count), 256'(m_dcnt));
        if (xi) check("i_rdata", i_rdata, l2_rdata);
        if (xd) check("d_rdata", d_rdata, l2_rdata);
        if (i_resp || d_resp) begin
            order = {order[4:0], i_resp};
            n_resp++;
        end
        if (m_owner != 0) begin
            if (l2_resp) begin
                if (m_owner == 1) ireq_pend = 1'b0;
                else dreq_pend = 1'b0;
                m_owner = 0;
            end
        end else begin
            dreq = d_read | d_write;
            if (i_read && (!dreq || m_streak >= STARVE_LIMIT)) begin
                m_owner  = 1;
                m_streak = 0;
                m_addr   = {i_addr[31:5], 5'b0};
                if (m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 32'd1;
                wait_cnt = int'($urandom_range(3));
            end else if (dreq) begin
                m_owner  = d_write ? 3 : 2;
                m_streak = i_read ? m_streak + 1 : 0;
                m_addr   = {d_addr[31:5], 5'b0};
                if (d_write) m_wdata = d_wdata;
                if (m_dcnt != 32'hFFFF_FFFF) m_dcnt = m_dcnt + 32'd1;
                wait_cnt = int'($urandom_range(3));
            end
        end
        @(negedge clk);
    endtask

    logic [255:0] wb_line;

    initial begin
        order  = '0;
        n_resp = 0;
        p_i = 0; p_d = 0; p_stray = 0; p_err = 0;
        do_reset();

        // Reset values.
        #1;
        check("rst_l2_read", 256'(l2_read), 256'(0));
        check("rst_l2_addr", 256'(l2_addr), 256'(0));
        check("rst_i_count", 256'(i_grant_count), 256'(0));
        @(negedge clk);

        // Single I-side read, L2 answers on the fourth strobe cycle.
        i_read = 1'b1;
        i_addr = 32'h0000_0064;
        tick();
        #1;
        check("single_addr", 256'(l2_addr), 256'(32'h0000_0060));
        check("single_read", 256'(l2_read), 256'(1));
        tick();
        tick();
        tick();
        l2_resp  = 1'b1;
        l2_rdata = {32{8'hA5}};
        #1;
        check("single_resp", 256'(i_resp), 256'(1));
        check("single_rdata", i_rdata, {32{8'hA5}});
        tick();
        clear_inputs();
        #1;
        check("single_count", 256'(i_grant_count), 256'(1));
        tick();

        // D-side write-back with requester inputs changing in flight.
        wb_line = {4{64'h0123_4567_89AB_CDEF}};
        d_write = 1'b1;
        d_addr  = 32'h1234_5678;
        d_wdata = wb_line;
        tick();
        d_wdata = ~wb_line;
        d_addr  = 32'hFFFF_FFFF;
        #1;
        check("wb_write", 256'(l2_write), 256'(1));
        check("wb_read", 256'(l2_read), 256'(0));
        check("wb_addr", 256'(l2_addr), 256'(32'h1234_5660));
        check("wb_wdata", l2_wdata, wb_line);
        tick();
        l2_resp = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Read and write together is handled as a write-back.
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_0100;
        d_wdata = {8{32'hDEAD_BEEF}};
        tick();
        #1;
        check("err_write", 256'(l2_write), 256'(1));
        check("err_read", 256'(l2_read), 256'(0));
        l2_resp = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Stray response while idle.
        l2_resp = 1'b1;
        #1;
        check("stray_i_resp", 256'(i_resp), 256'(0));
        check("stray_d_resp", 256'(d_resp), 256'(0));
        tick();
        l2_resp = 1'b0;
        #1;
        check("stray_idle", 256'({l2_read, l2_write}), 256'(0));
        tick();

        // Grant order under contention starting from a cleared streak.
        do_reset();
        p_i = 100; p_d = 100; p_stray = 0; p_err = 0;
        n_resp = 0;
        for (int c = 0; c < 200 && n_resp < 6; c++) begin
            drive_random();
            tick();
        end
        check("order_done", 256'(n_resp), 256'(6));
        check("grant_order", 256'(order), 256'(6'b001001));

        // Reset mid-transaction.
        do_reset();
        i_read = 1'b1;
        i_addr = 32'h0000_0200;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("abort_read", 256'(l2_read), 256'(0));
        check("abort_i_count", 256'(i_grant_count), 256'(0));
        check("abort_d_count", 256'(d_grant_count), 256'(0));
        @(negedge clk);
        clear_inputs();
        model_reset();
        rst = 1'b1;
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick();

        // Counter saturation.
        force dut.d_grant_count = 32'hFFFF_FFFE;
        #1;
        release dut.d_grant_count;
        m_dcnt = 32'hFFFF_FFFE;
        p_i = 0; p_d = 100; p_stray = 0; p_err = 0;
        for (int c = 0; c < 20; c++) begin
            drive_random();
            tick();
        end
        check("sat_count", 256'(d_grant_count), 256'(32'hFFFF_FFFF));

        // Long randomized run.
        do_reset();
        p_i = 40; p_d = 50; p_stray = 10; p_err = 5;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
